// File: rtl/mcs_req_arbiter.sv
// Round-robin arbiter sharing the MCS GPI1/GPO1 compute channel among NREQ requesters,
// using a toggle handshake on GPI2[0]/GPO2[0]. Optional WAIT timeout: define MCS_ARB_TIMEOUT_EN.
module mcs_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk_fpga,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          result,
    output logic                 timeout_err,
    output logic [31:0]          mcs_gpi1,
    output logic [7:0]           mcs_gpi2,
    input  logic [31:0]          mcs_gpo1,
    input  logic [7:0]           mcs_gpo2
);

    localparam int CW = ((TIMEOUT + 1) > 1024) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [2:0] LAST_INIT = 3'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_reg;
    logic [NREQ-1:0]   grant_reg;
    logic [NREQ-1:0]   done_reg;
    logic [31:0]       result_reg;
    logic [31:0]       gpi1_reg;
    logic [2:0]        id_reg;
    logic [2:0]        last_reg;
    logic              req_tog_reg;
    logic              ack_q_reg;
    logic              timeout_err_reg;

    logic [7:0]        req_ext;
    logic [31:0]       operand_ext [8];
    logic [NREQ-1:0]   sel_onehot;
    logic              sel_found;
    logic [2:0]        sel_idx;
    logic [2:0]        cand;

    logic [6:0]        unused_gpo2;
    assign unused_gpo2 = mcs_gpo2[7:1];

    assign req_ext = 8'(req);

    // Operands padded to eight slots so a 3-bit index is always in range.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_operand
            if (gi < NREQ) begin : g_used
                assign operand_ext[gi] = req_data[32*gi +: 32];
            end else begin : g_pad
                assign operand_ext[gi] = 32'h0;
            end
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_idx == 3'(gi));
        end
    endgenerate

    // First active request scanning upward from the requester after the last winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        cand      = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 3'((int'(last_reg) + k) % NREQ);
            if (!sel_found && req_ext[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef MCS_ARB_TIMEOUT_EN
    logic [CW-1:0] wait_cnt_reg;
`else
    logic [CW-1:0] unused_timeout;
    assign unused_timeout = CW'(TIMEOUT);
`endif

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            done_reg        <= '0;
            result_reg      <= 32'h0;
            gpi1_reg        <= 32'h0;
            id_reg          <= 3'd0;
            last_reg        <= LAST_INIT;
            req_tog_reg     <= 1'b0;
            ack_q_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef MCS_ARB_TIMEOUT_EN
            wait_cnt_reg    <= '0;
`endif
        end else begin
            ack_q_reg <= mcs_gpo2[0];
            done_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        grant_reg <= sel_onehot;
                        gpi1_reg  <= operand_ext[sel_idx];
                        id_reg    <= sel_idx;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    req_tog_reg <= ~req_tog_reg;
`ifdef MCS_ARB_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (ack_q_reg == req_tog_reg) begin
                        result_reg <= mcs_gpo1;
                        done_reg   <= grant_reg;
                        state_reg  <= DONE;
                    end
`ifdef MCS_ARB_TIMEOUT_EN
                    else if (wait_cnt_reg == CW'(TIMEOUT)) begin
                        // Realign so a late ack reads as an already-matched channel.
                        result_reg      <= 32'hFFFF_FFFF;
                        timeout_err_reg <= 1'b1;
                        req_tog_reg     <= ack_q_reg;
                        done_reg        <= grant_reg;
                        state_reg       <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                DONE: begin
                    grant_reg <= '0;
                    last_reg  <= id_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant    = grant_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign mcs_gpi1 = gpi1_reg;
    assign mcs_gpi2 = {4'b0000, id_reg, req_tog_reg};
`ifdef MCS_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcs_req_arbiter.sv
// Randomized bench for mcs_req_arbiter: firmware model, edge-timestamp reference model
// and per-cycle output checks. Timeout scenario runs when MCS_ARB_TIMEOUT_EN is defined.
module tb_mcs_req_arbiter;

    localparam int NREQ = 4;
`ifdef MCS_ARB_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 1023;
`endif

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic [31:0]         result;
    logic                timeout_err;
    logic [31:0]         mcs_gpi1;
    logic [7:0]          mcs_gpi2;
    logic [31:0]         mcs_gpo1;
    logic [7:0]          mcs_gpo2;

    int errs = 0;
    int checks = 0;
    int txns = 0;
    bit mon_en = 0;

    // firmware controls (main) and firmware state (firmware process)
    bit fw_en = 1;
    int fw_fixed = -1;
    bit fw_busy;
    int fw_left;
    int fw_ack_edge = -100;

    // reference model
    int cyc = 0;
    int m_owner, m_last, m_free, m_issue_edge, m_done_edge;
    logic [31:0] m_data;
    logic [NREQ-1:0] e_grant, e_done;
    logic [31:0] e_result, e_gpi1;
    logic [2:0] e_id;
    logic e_tog, e_terr;

    mcs_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk_fpga    (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .result      (result),
        .timeout_err (timeout_err),
        .mcs_gpi1    (mcs_gpi1),
        .mcs_gpi2    (mcs_gpi2),
        .mcs_gpo1    (mcs_gpo1),
        .mcs_gpo2    (mcs_gpo2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, input int bound);
        d = '0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done != '0) begin
                d = done;
                break;
            end
        end
        check_val("done_seen", 32'(d != '0), 32'd1);
    endtask

    // Reference model: transaction rules expressed as edge timestamps.
    always @(posedge clk or negedge reset) begin : model
        int n;
        int w;
        int c;
        if (!reset) begin
            m_owner = -1; m_last = NREQ - 1; m_free = 0;
            m_issue_edge = -100; m_done_edge = -100;
            e_grant = '0; e_done = '0; e_result = 0; e_gpi1 = 0;
            e_id = 0; e_tog = 0; e_terr = 0;
        end else begin
            cyc = cyc + 1;
            n = cyc;
            if (m_owner >= 0) begin
                if (m_done_edge >= 0 && n == m_done_edge + 1) begin
                    e_done = '0;
                    e_grant = '0;
                    m_last = m_owner;
                    m_owner = -1;
                    m_free = n + 1;
                end else if (m_done_edge < 0) begin
                    if (n == m_issue_edge) begin
                        e_tog = ~e_tog;
                    end else if (fw_ack_edge > m_issue_edge && n == fw_ack_edge + 1) begin
                        e_done = e_grant;
                        e_result = m_data + 1;
                        m_done_edge = n;
                    end
`ifdef MCS_ARB_TIMEOUT_EN
                    else if (n == m_issue_edge + TO + 1) begin
                        e_done = e_grant;
                        e_result = 32'hFFFF_FFFF;
                        e_terr = 1;
                        e_tog = ~e_tog;
                        m_done_edge = n;
                    end
`endif
                end
            end else if (n >= m_free && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (w < 0 && req[c]) w = c;
                end
                m_owner = w;
                m_data = req_data[32*w +: 32];
                e_grant = NREQ'(1) << w;
                e_gpi1 = m_data;
                e_id = 3'(w);
                m_issue_edge = n + 1;
                m_done_edge = -100;
            end
        end
    end

    // Firmware: after a programmable delay returns operand+1 and echoes the toggle.
    initial begin
        mcs_gpo1 = 0;
        mcs_gpo2 = 0;
        fw_busy = 0;
        fw_left = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mcs_gpo1 = 0;
                mcs_gpo2 = 0;
                fw_busy = 0;
            end else if (fw_en) begin
                if (!fw_busy && mcs_gpi2[0] != mcs_gpo2[0]) begin
                    fw_busy = 1;
                    fw_left = (fw_fixed >= 0) ? fw_fixed : int'($urandom_range(0, 12));
                end
                if (fw_busy) begin
                    if (fw_left == 0) begin
                        mcs_gpo1 = mcs_gpi1 + 1;
                        mcs_gpo2[0] = mcs_gpi2[0];
                        fw_busy = 0;
                        fw_ack_edge = cyc + 1;
                    end else begin
                        fw_left--;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_val("grant", 32'(grant), 32'(e_grant));
                check_val("done", 32'(done), 32'(e_done));
                check_val("result", result, e_result);
                check_val("gpi1", mcs_gpi1, e_gpi1);
                check_val("gpi2", 32'(mcs_gpi2), {24'h0, 4'h0, e_id, e_tog});
                check_val("timeout_err", 32'(timeout_err), 32'(e_terr));
                if (done != '0) begin
                    txns++;
                    $display("txn %0d: done=%b result=%h", txns, done, result);
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        reset = 0;
        repeat (cycles) tick();
        reset = 1;
    endtask

    initial begin
        logic [NREQ-1:0] d;
        int idx;
        reset = 0;
        req = '0;
        req_data = '0;
        repeat (2) tick();
        mon_en = 1;
        tick();
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_gpi1", mcs_gpi1, 32'd0);
        check_val("rst_gpi2", 32'(mcs_gpi2), 32'd0);
        check_val("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1;
        tick();

        // single request
        fw_fixed = 10;
        req_data[31:0] = 32'h0000_0005;
        req = 4'b0001;
        tick();
        tick();
        check_val("single_grant", 32'(grant), 32'h1);
        check_val("single_gpi2", 32'(mcs_gpi2), 32'h01);
        wait_done(d, 60);
        check_val("single_done", 32'(d), 32'h1);
        check_val("single_result", result, 32'h0000_0006);
        req = '0;
        repeat (4) tick();

        // round robin from a fresh reset
        do_reset(2);
        fw_fixed = 2;
        for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'(i * 16);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(d, 60);
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (d[i]) idx = i;
            check_val("rr_order", 32'(idx), 32'(k % NREQ));
            check_val("rr_result", result, 32'(idx * 16 + 1));
        end
        req = '0;
        repeat (4) tick();

        // late join
        fw_fixed = 10;
        req_data[95:64] = 32'hA0;
        req_data[63:32] = 32'hB0;
        req = 4'b0100;
        repeat (5) tick();
        req[1] = 1'b1;
        tick();
        check_val("late_grant", 32'(grant), 32'h4);
        wait_done(d, 60);
        check_val("late_first", 32'(d), 32'h4);
        req[2] = 1'b0;
        wait_done(d, 60);
        check_val("late_second", 32'(d), 32'h2);
        req = '0;
        repeat (4) tick();

        // reset mid-WAIT
        req_data[31:0] = 32'h1234;
        req = 4'b0001;
        repeat (6) tick();
        reset = 0;
        tick();
        check_val("midrst_grant", 32'(grant), 32'd0);
        check_val("midrst_gpi2", 32'(mcs_gpi2), 32'd0);
        check_val("midrst_result", result, 32'd0);
        tick();
        reset = 1;
        tick();
        tick();
        check_val("post_rst_tog", 32'(mcs_gpi2[0]), 32'd1);
        wait_done(d, 60);
        check_val("post_rst_done", 32'(d), 32'h1);
        check_val("post_rst_result", result, 32'h1235);
        req = '0;
        repeat (4) tick();

        // requester drops in WAIT
        fw_fixed = 6;
        req_data[63:32] = 32'h77;
        req = 4'b0010;
        repeat (4) tick();
        req = '0;
        wait_done(d, 60);
        check_val("drop_done", 32'(d), 32'h2);
        tick();
        check_val("drop_idle_grant", 32'(grant), 32'd0);
        repeat (3) tick();

`ifdef MCS_ARB_TIMEOUT_EN
        fw_en = 0;
        req_data[31:0] = 32'h50;
        req = 4'b0001;
        wait_done(d, 80);
        check_val("to_result", result, 32'hFFFF_FFFF);
        check_val("to_terr", 32'(timeout_err), 32'd1);
        req = '0;
        repeat (3) tick();
        fw_en = 1;
        req = 4'b0001;
        wait_done(d, 80);
        check_val("to_next_result", result, 32'h51);
        check_val("to_terr_sticky", 32'(timeout_err), 32'd1);
        req = '0;
        repeat (3) tick();
`endif

        // randomized traffic
        fw_fixed = -1;
        for (int t = 0; t < 2500; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_data[32*i +: 32] = $urandom;
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (40) tick();
        check_val("drain_grant", 32'(grant), 32'd0);
        check_val("txn_count", 32'(txns > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mcs_req_arbiter.md
# mcs_req_arbiter

Round-robin arbiter and transaction sequencer sharing the single MicroBlaze MCS compute channel (GPI1 operand in, GPO1 result out) among NREQ hardware requesters. It sits between the requester logic and the `communication` MCS instance. It presents one operand at a time on GPI1 and signals the firmware through a toggle handshake on GPI2/GPO2. It then captures the firmware's GPO1 result and returns it to the granted requester with a one-cycle done pulse.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `TIMEOUT`, 1023: WAIT-state cycle limit; used only with timeout compiled in
- `clk_fpga`  in  1  system clock; the MCS runs on the same clock
- `reset`  in  1  asynchronous, active-low reset (asserts on low, clears all state immediately)
- `req`  in  NREQ  per-requester request level; held until the matching `done`
- `req_data`  in  32*NREQ  operands; requester i uses bits [32i+31:32i]
- `grant`  out  NREQ  one-hot owner of the channel; all-zero when idle
- `done`  out  NREQ  one-cycle pulse to the owner when `result` is valid
- `result`  out  32  last captured result; held until the next capture
- `timeout_err`  out  1  sticky flag set on timeout; cleared only by reset
- `mcs_gpi1`  out  32  operand to MCS GPI1
- `mcs_gpi2`  out  8  [0] request toggle, [3:1] requester id, [7:4] zero
- `mcs_gpo1`  in  32  result from MCS GPO1
- `mcs_gpo2`  in  8  [0] firmware ack toggle; other bits ignored

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req` bit is set, select the first set bit scanning upward from `last+1` (mod NREQ).
  - Register `grant`, `mcs_gpi1` = that operand, and id, then go to ISSUE.
  - `last` resets to NREQ-1, so requester 0 wins first.
- ISSUE: toggle `req_tog` (drives `mcs_gpi2[0]`), then go to WAIT. Lasting one cycle.
- WAIT:
  - `ack_q` is a registered copy of `mcs_gpo2[0]`.
  - When `ack_q == req_tog`, capture `mcs_gpo1` into `result` and go to DONE.
- DONE:
  - `done[id]` is high for this one cycle, `grant` is still held, and `last` is set to id.
  - Next state is IDLE, with `grant` cleared.
- Firmware contract: read GPI2/GPI1, write GPO1, then set GPO2[0] = GPI2[0]. At reset both toggles are 0, so the channel starts matched.
- Dropping `req` mid-transaction does not abort the transaction. `done` still pulses, and the requester ignores it.
- A `req` that rises while another requester is granted waits for IDLE. There is no preemption.
- `mcs_gpi1` and `mcs_gpi2[3:1]` hold their values from grant until the next grant.
- Reset values:
  - `grant`=0, `done`=0, `result`=0, `timeout_err`=0
  - `mcs_gpi1`=0, `mcs_gpi2`=0
  - `req_tog`=0, `ack_q`=0, state=IDLE
- Reset mid-transaction returns to IDLE immediately. Firmware must re-sync GPO2[0] to 0 after an MCS reset.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Edge 1 after `req` is sampled in IDLE: `grant`/`mcs_gpi1` valid. Edge 2: toggle visible.
- Firmware ack at edge k gives `ack_q` at k+1 and DONE at k+2.
- Minimum `req`→`done` is 5 cycles.
- Back-to-back: at most one IDLE cycle between transactions.
- The IDLE→grant decision uses `req` sampled that cycle. A request raised the same cycle as DONE is seen in the following IDLE.

## Configuration
- `MCS_ARB_TIMEOUT_EN` defined: a 10-bit minimum counter (width ≥ clog2(TIMEOUT+1)) counts cycles in WAIT.
- On reaching TIMEOUT without an ack:
  - `result` = 32'hFFFF_FFFF, `timeout_err` set, go to DONE (`done` pulses normally).
  - `req_tog` is realigned to `ack_q`, so a late firmware ack is absorbed as a match.
- Undefined: WAIT waits indefinitely, the counter is absent, and `timeout_err` is tied to 0.

## Test plan
- Single request: req=0001, data0=32'h0000_0005, firmware model returns data+1 after 10 cycles → `grant`=0001, `mcs_gpi2`=8'h01, `done`=0001 pulse, `result`=32'h0000_0006. Latency 10+4 cycles.
- Round-robin: req=1111 held, data i = i*16 → grants in order 0,1,2,3,0. Each `done` pulse matches the grant, and `result` = data+1.
- Late join: req=0100 granted, then req[1] raised mid-WAIT → req[1] served only after `done`=0100. `grant` stays 0100 throughout WAIT.
- Reset mid-WAIT: reset low for 2 cycles during WAIT → all outputs are 0 during reset. After release, req=0001 gives a fresh grant with `mcs_gpi2[0]` toggling 0→1.
- Timeout (with `MCS_ARB_TIMEOUT_EN`, TIMEOUT=20): firmware never acks → `done` pulses TIMEOUT+1 cycles after WAIT entry, `result`=FFFF_FFFF, `timeout_err`=1. The next request completes normally.
- Requester drop: req=0010 deasserted in WAIT → transaction completes, `done`=0010 pulses, then the FSM returns to IDLE with `grant`=0.
